// File: rtl/decode_buffer_stage_pkg.sv
// Shared types and RV32I opcode constants for the buffered decode stage.
// Imported by the instruction FIFO and the decode_buffer_stage top.
package decode_buffer_stage_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] next_pc;
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]  inst;
        fetch_state_t fetch_state;
    } fetch_entry_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic [31:0] i_immed;
        logic [31:0] s_immed;
        logic [31:0] b_immed;
        logic [31:0] u_immed;
        logic [31:0] j_immed;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic        rf_wr_en;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jal;
        logic        jalr;
    } decode_state_t;

    typedef struct packed {
        logic        rs1_used;
        logic        rs2_used;
        logic        rd_used;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
    } reg_meta_t;

    function automatic logic is_legal_opcode(input logic [6:0] opc);
        return opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
                           OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM};
    endfunction

endpackage

// File: rtl/decode_buffer_stage_fifo.sv
// Power-of-two circular instruction buffer with occupancy count and synchronous flush.
// Pointers wrap naturally because DEPTH is a power of two.
module decode_fifo
    import decode_buffer_stage_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  T                           wr_data,
    output T                           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    T               mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed while counted as valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/decode_buffer_stage.sv
// Buffered RV32I decode stage: fetch entries queue in a small FIFO, the head is decoded
// combinationally and captured into a valid/ready output register (optional empty bypass).
module decode_buffer_stage
    import decode_buffer_stage_pkg::*;
#(
    parameter int DEPTH       = 2,
    parameter bit BYPASS      = 1'b1,
    parameter bit ILLEGAL_CHK = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  fetch_state_t               fetch_state_i,
    input  logic [31:0]                inst_i,
    input  logic                       squash_i,
    output logic [4:0]                 rf_port1_reg_o,
    output logic [4:0]                 rf_port2_reg_o,
    input  logic [31:0]                rf_rs1_i,
    input  logic [31:0]                rf_rs2_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output decode_state_t              decode_state_o,
    output reg_meta_t                  reg_meta_o,
    output logic                       illegal_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);
    fetch_entry_t  in_entry;
    fetch_entry_t  fifo_head;
    fetch_entry_t  head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    logic          push;
    logic          load;
    logic          head_valid;
    logic          pop;
    logic          bypass_take;
    logic [31:0]   inst;
    logic [6:0]    opcode;
    logic          writes_rd;
    logic          illegal;
    decode_state_t dec;
    reg_meta_t     meta;

    assign in_entry    = '{inst: inst_i, fetch_state: fetch_state_i};
    assign ready_o     = ~fifo_full;
    assign push        = valid_i & ready_o & ~squash_i;
    assign load        = (~valid_o | ready_i) & ~squash_i;
    assign head_valid  = ~fifo_empty | (BYPASS && push);
    assign pop         = load & head_valid;
    assign bypass_take = BYPASS && (fifo_empty & push & load);
    assign fifo_push   = push & ~bypass_take;
    assign fifo_pop    = load & ~fifo_empty;

    decode_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_fifo (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .flush   (squash_i),
        .wr_data (in_entry),
        .head    (fifo_head),
        .count   (occupancy_o),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head           = (fifo_empty && BYPASS) ? in_entry : fifo_head;
    assign inst           = head.inst;
    assign opcode         = inst[6:0];
    assign rf_port1_reg_o = inst[19:15];
    assign rf_port2_reg_o = inst[24:20];

    // Illegal words suppress every architectural side effect, not just the flag.
    always_comb begin
        dec       = '0;
        meta      = '0;
        illegal   = ILLEGAL_CHK && !is_legal_opcode(opcode);
        writes_rd = opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD,
                                   OPC_OP_IMM, OPC_OP};

        dec.pc        = head.fetch_state.pc;
        dec.next_pc   = head.fetch_state.next_pc;
        dec.i_immed   = {{20{inst[31]}}, inst[31:20]};
        dec.s_immed   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        dec.b_immed   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        dec.u_immed   = {inst[31:12], 12'b0};
        dec.j_immed   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        dec.opcode    = opcode;
        dec.funct3    = inst[14:12];
        dec.funct7    = inst[31:25];
        dec.rf_wr_en  = writes_rd && (inst[11:7] != 5'd0) && !illegal;
        dec.mem_read  = (opcode == OPC_LOAD) && !illegal;
        dec.mem_write = (opcode == OPC_STORE) && !illegal;
        dec.branch    = (opcode == OPC_BRANCH);
        dec.jal       = (opcode == OPC_JAL);
        dec.jalr      = (opcode == OPC_JALR);

        meta.rs1_used = opcode inside {OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE,
                                       OPC_OP_IMM, OPC_OP};
        meta.rs2_used = opcode inside {OPC_BRANCH, OPC_STORE, OPC_OP};
        meta.rd_used  = writes_rd && !illegal;
        meta.rs1_addr = inst[19:15];
        meta.rs2_addr = inst[24:20];
        meta.rd_addr  = inst[11:7];
        meta.rs1_data = rf_rs1_i;
        meta.rs2_data = rf_rs2_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o        <= 1'b0;
            decode_state_o <= '0;
            reg_meta_o     <= '0;
            illegal_o      <= 1'b0;
        end else if (pop) begin
            valid_o        <= 1'b1;
            decode_state_o <= dec;
            reg_meta_o     <= meta;
            illegal_o      <= illegal;
        end else if (squash_i || load) begin
            valid_o        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_buffer_stage.sv
// Self-checking bench for decode_buffer_stage: decode vector table, handshake corner
// sequences and a randomized run, all checked against a queue-based reference model.
module tb_decode_buffer_stage;
    import decode_buffer_stage_pkg::*;

    localparam int DEPTH = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          valid_i;
    logic          ready_o;
    fetch_state_t  fetch_state_i;
    logic [31:0]   inst_i;
    logic          squash_i;
    logic [4:0]    rf_port1_reg_o;
    logic [4:0]    rf_port2_reg_o;
    logic [31:0]   rf_rs1_i;
    logic [31:0]   rf_rs2_i;
    logic          valid_o;
    logic          ready_i;
    decode_state_t decode_state_o;
    reg_meta_t     reg_meta_o;
    logic          illegal_o;
    logic [1:0]    occupancy_o;

    int checks   = 0;
    int failures = 0;

    decode_buffer_stage #(.DEPTH(DEPTH), .BYPASS(1'b1), .ILLEGAL_CHK(1'b1)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .fetch_state_i  (fetch_state_i),
        .inst_i         (inst_i),
        .squash_i       (squash_i),
        .rf_port1_reg_o (rf_port1_reg_o),
        .rf_port2_reg_o (rf_port2_reg_o),
        .rf_rs1_i       (rf_rs1_i),
        .rf_rs2_i       (rf_rs2_i),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .decode_state_o (decode_state_o),
        .reg_meta_o     (reg_meta_o),
        .illegal_o      (illegal_o),
        .occupancy_o    (occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: pending entries in a queue plus the word held at the output.
    fetch_entry_t mq[$];
    logic         m_valid;
    logic [31:0]  m_inst, m_pc, m_npc, m_rs1, m_rs2;

    typedef struct {
        logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
        logic        ill, rf_wr, mr, mw, rd_used;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        ill, rf_wr, mr, mw, rd_used;
        logic [31:0] i_imm;
    } vec_t;

    vec_t vecs[8];

    function automatic exp_t refDecode(input logic [31:0] w);
        exp_t        e;
        logic [6:0]  opc;
        logic [31:0] sgn, rd;
        logic        writes;
        opc    = w[6:0];
        rd     = (w >> 7) % 32;
        sgn    = (w[31]) ? 32'hFFFFFFFF : 32'h0;
        e.ill  = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL || opc == OPC_JALR ||
                   opc == OPC_BRANCH || opc == OPC_LOAD || opc == OPC_STORE ||
                   opc == OPC_OP_IMM || opc == OPC_OP || opc == OPC_MISC_MEM ||
                   opc == OPC_SYSTEM);
        writes = (opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL || opc == OPC_JALR ||
                  opc == OPC_LOAD || opc == OPC_OP_IMM || opc == OPC_OP);
        e.rf_wr   = writes && !e.ill && rd != 0;
        e.mr      = (opc == OPC_LOAD) && !e.ill;
        e.mw      = (opc == OPC_STORE) && !e.ill;
        e.rd_used = writes && !e.ill;
        e.i_imm   = sgn * 4096 + (w >> 20);
        e.s_imm   = sgn * 4096 + ((w >> 25) % 128) * 32 + rd;
        e.b_imm   = sgn * 4096 + ((w >> 7) % 2) * 2048 + ((w >> 25) % 64) * 32 + ((w >> 8) % 16) * 2;
        e.u_imm   = (w >> 12) * 4096;
        e.j_imm   = sgn * 1048576 + ((w >> 12) % 256) * 4096 + ((w >> 20) % 2) * 2048
                    + ((w >> 21) % 1024) * 2;
        return e;
    endfunction

    function automatic void modelReset();
        mq.delete();
        m_valid = 1'b0;
    endfunction

    function automatic void capture(input fetch_entry_t e);
        m_valid = 1'b1;
        m_inst  = e.inst;
        m_pc    = e.fetch_state.pc;
        m_npc   = e.fetch_state.next_pc;
        m_rs1   = rf_rs1_i;
        m_rs2   = rf_rs2_i;
    endfunction

    function automatic void modelStep();
        fetch_entry_t in_e;
        logic         rdy, push, load;
        in_e.inst        = inst_i;
        in_e.fetch_state = fetch_state_i;
        rdy  = mq.size() < DEPTH;
        push = valid_i && rdy && !squash_i;
        load = (!m_valid || ready_i) && !squash_i;
        if (squash_i) begin
            mq.delete();
            m_valid = 1'b0;
        end else if (load) begin
            if (mq.size() > 0) begin
                capture(mq.pop_front());
                if (push) mq.push_back(in_e);
            end else if (push) begin
                capture(in_e);
            end else begin
                m_valid = 1'b0;
            end
        end else if (push) begin
            mq.push_back(in_e);
        end
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] w, input logic [31:0] pc,
                                 input logic rdy, input logic sq);
        valid_i               = v;
        inst_i                = w;
        fetch_state_i.pc      = pc;
        fetch_state_i.next_pc = pc + 32'd4;
        ready_i               = rdy;
        squash_i              = sq;
        rf_rs1_i              = $urandom();
        rf_rs2_i              = $urandom();
        @(posedge clk_i);
        modelStep();
        #1;
    endtask

    task automatic checkOutput(input string tag);
        exp_t        e;
        logic [31:0] h;
        compare({tag, ".valid"}, 32'(valid_o), 32'(m_valid));
        compare({tag, ".ready"}, 32'(ready_o), 32'(mq.size() < DEPTH));
        compare({tag, ".occ"}, 32'(occupancy_o), 32'(mq.size()));
        h = (mq.size() > 0) ? mq[0].inst : inst_i;
        compare({tag, ".rfport1"}, 32'(rf_port1_reg_o), (h >> 15) % 32);
        compare({tag, ".rfport2"}, 32'(rf_port2_reg_o), (h >> 20) % 32);
        if (m_valid) begin
            e = refDecode(m_inst);
            compare({tag, ".pc"}, decode_state_o.pc, m_pc);
            compare({tag, ".npc"}, decode_state_o.next_pc, m_npc);
            compare({tag, ".iimm"}, decode_state_o.i_immed, e.i_imm);
            compare({tag, ".simm"}, decode_state_o.s_immed, e.s_imm);
            compare({tag, ".bimm"}, decode_state_o.b_immed, e.b_imm);
            compare({tag, ".uimm"}, decode_state_o.u_immed, e.u_imm);
            compare({tag, ".jimm"}, decode_state_o.j_immed, e.j_imm);
            compare({tag, ".rfwr"}, 32'(decode_state_o.rf_wr_en), 32'(e.rf_wr));
            compare({tag, ".mrd"}, 32'(decode_state_o.mem_read), 32'(e.mr));
            compare({tag, ".mwr"}, 32'(decode_state_o.mem_write), 32'(e.mw));
            compare({tag, ".ill"}, 32'(illegal_o), 32'(e.ill));
            compare({tag, ".rdused"}, 32'(reg_meta_o.rd_used), 32'(e.rd_used));
            compare({tag, ".rdaddr"}, 32'(reg_meta_o.rd_addr), (m_inst >> 7) % 32);
            compare({tag, ".rs1data"}, reg_meta_o.rs1_data, m_rs1);
            compare({tag, ".rs2data"}, reg_meta_o.rs2_data, m_rs2);
        end
    endtask

    task automatic fillThree(input logic [31:0] base);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 32'h00100093 + 32'(k) * 32'h00100000, base + 32'(4 * k), 1'b0, 1'b0);
            checkOutput($sformatf("fill%0h_%0d", base, k));
        end
    endtask

    initial begin
        logic [6:0]  opcs[11];
        logic [31:0] w, opc;

        vecs[0] = '{32'h00700293, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00000007};
        vecs[1] = '{32'h00000000, 32'h104, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000};
        vecs[2] = '{32'h00100013, 32'h108, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000001};
        vecs[3] = '{32'hFFC12183, 32'h10C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFC};
        vecs[4] = '{32'h0060A423, 32'h110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000006};
        vecs[5] = '{32'h123450B7, 32'h114, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00000123};
        vecs[6] = '{32'h0000007F, 32'h118, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000};
        vecs[7] = '{32'h00000091, 32'h11C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000};
        opcs = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE,
                 OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM};

        rst_ni = 1'b0; valid_i = 1'b0; inst_i = '0; fetch_state_i = '0;
        ready_i = 1'b0; squash_i = 1'b0; rf_rs1_i = '0; rf_rs2_i = '0;
        modelReset();
        repeat (2) @(posedge clk_i);
        #1;
        compare("reset.valid", 32'(valid_o), 32'd0);
        compare("reset.occ", 32'(occupancy_o), 32'd0);
        compare("reset.ready", 32'(ready_o), 32'd1);
        compare("reset.ill", 32'(illegal_o), 32'd0);
        compare("reset.dec_zero", 32'(decode_state_o == '0), 32'd1);
        compare("reset.meta_zero", 32'(reg_meta_o == '0), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;

        $display("[TB] decode vector table via bypass path");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, vecs[i].inst, vecs[i].pc, 1'b1, 1'b0);
            checkOutput($sformatf("vec%0d", i));
            compare($sformatf("vec%0d.k_valid", i), 32'(valid_o), 32'd1);
            compare($sformatf("vec%0d.k_occ", i), 32'(occupancy_o), 32'd0);
            compare($sformatf("vec%0d.k_pc", i), decode_state_o.pc, vecs[i].pc);
            compare($sformatf("vec%0d.k_ill", i), 32'(illegal_o), 32'(vecs[i].ill));
            compare($sformatf("vec%0d.k_rfwr", i), 32'(decode_state_o.rf_wr_en), 32'(vecs[i].rf_wr));
            compare($sformatf("vec%0d.k_mrd", i), 32'(decode_state_o.mem_read), 32'(vecs[i].mr));
            compare($sformatf("vec%0d.k_mwr", i), 32'(decode_state_o.mem_write), 32'(vecs[i].mw));
            compare($sformatf("vec%0d.k_rdused", i), 32'(reg_meta_o.rd_used), 32'(vecs[i].rd_used));
            compare($sformatf("vec%0d.k_iimm", i), decode_state_o.i_immed, vecs[i].i_imm);
        end
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("drain0");

        $display("[TB] fill to full and release");
        fillThree(32'h200);
        compare("full.k_occ", 32'(occupancy_o), 32'd2);
        compare("full.k_ready", 32'(ready_o), 32'd0);
        applyStimulus(1'b1, 32'h00500013, 32'h20C, 1'b0, 1'b0);
        checkOutput("full.ignored");
        compare("full.ignored.k_occ", 32'(occupancy_o), 32'd2);
        compare("full.ignored.k_pc", decode_state_o.pc, 32'h200);
        for (int k = 1; k <= 2; k++) begin
            applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
            checkOutput($sformatf("release%0d", k));
            compare($sformatf("release%0d.k_pc", k), decode_state_o.pc, 32'h200 + 32'(4 * k));
            compare($sformatf("release%0d.k_ready", k), 32'(ready_o), 32'd1);
        end
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("release_end");
        compare("release_end.k_valid", 32'(valid_o), 32'd0);

        $display("[TB] steady push/pop at count one");
        applyStimulus(1'b1, 32'h00000013, 32'h400, 1'b0, 1'b0);
        checkOutput("steady.a");
        applyStimulus(1'b1, 32'h00108113, 32'h404, 1'b0, 1'b0);
        checkOutput("steady.b");
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 32'h00208113 + 32'(k) * 32'h00100000, 32'h408 + 32'(4 * k), 1'b1, 1'b0);
            checkOutput($sformatf("steady%0d", k));
            compare($sformatf("steady%0d.k_occ", k), 32'(occupancy_o), 32'd1);
            compare($sformatf("steady%0d.k_pc", k), decode_state_o.pc, 32'h404 + 32'(4 * k));
        end
        repeat (3) begin
            applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
            checkOutput("steady.drain");
        end

        $display("[TB] squash with full buffer and same-cycle push");
        fillThree(32'h300);
        applyStimulus(1'b1, 32'h00700293, 32'h30C, 1'b0, 1'b1);
        checkOutput("squash");
        compare("squash.k_valid", 32'(valid_o), 32'd0);
        compare("squash.k_occ", 32'(occupancy_o), 32'd0);
        compare("squash.k_ready", 32'(ready_o), 32'd1);
        repeat (2) begin
            applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
            checkOutput("squash.after");
            compare("squash.after.k_valid", 32'(valid_o), 32'd0);
        end

        $display("[TB] asynchronous reset mid-stream");
        fillThree(32'h500);
        compare("premid.k_occ", 32'(occupancy_o), 32'd2);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        modelReset();
        compare("midrst.valid", 32'(valid_o), 32'd0);
        compare("midrst.occ", 32'(occupancy_o), 32'd0);
        compare("midrst.ill", 32'(illegal_o), 32'd0);
        compare("midrst.dec_zero", 32'(decode_state_o == '0), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        applyStimulus(1'b1, 32'h00700293, 32'h100, 1'b1, 1'b0);
        checkOutput("postrst");
        compare("postrst.k_valid", 32'(valid_o), 32'd1);
        compare("postrst.k_pc", decode_state_o.pc, 32'h100);
        compare("postrst.k_iimm", decode_state_o.i_immed, 32'd7);
        compare("postrst.k_rfwr", 32'(decode_state_o.rf_wr_en), 32'd1);
        compare("postrst.k_occ", 32'(occupancy_o), 32'd0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            opc = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 127))
                                              : 32'(opcs[$urandom_range(0, 10)]);
            w = ($urandom() & 32'hFFFFFF80) | opc;
            applyStimulus(1'($urandom_range(0, 9) < 7), w, 32'h1000 + 32'(4 * i),
                          1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 24) == 0));
            checkOutput($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_buffer_stage.md
Name: decode_buffer_stage

Overview:
Parametrised successor to the single-register decode stage. Replaces the global stall with valid/ready handshakes on both sides, and adds a DEPTH-entry instruction buffer that decouples fetch from execute. It also adds an optional empty-buffer bypass and RV32I illegal-opcode detection. Sits between fetch and execute; reuses decoder and immed_gen on the buffer head.

Parameters:
DEPTH, 2, buffer entries; power of two, >= 2
BYPASS, 1, 1 = empty buffer and loadable output register take input directly (1-cycle latency)
ILLEGAL_CHK, 1, 1 = enable illegal-opcode detection; 0 = illegal_o tied 0

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
valid_i  in  1  fetch entry valid
ready_o  out  1  buffer can accept; = (count < DEPTH); registered-state only, no path from ready_i
fetch_state_i  in  fetch_state_t  pc / next_pc of entry
inst_i  in  32  instruction word
squash_i  in  1  flush buffer and output register
rf_port1_reg_o  out  5  head inst[19:15]
rf_port2_reg_o  out  5  head inst[24:20]
rf_rs1_i  in  32  RF read data port 1 (combinational)
rf_rs2_i  in  32  RF read data port 2
valid_o  out  1  output register valid
ready_i  in  1  execute accepts
decode_state_o  out  decode_state_t  decoded control, immediates, pc
reg_meta_o  out  reg_meta_t  rs1/rs2/rd used, addresses, rs data
illegal_o  out  1  registered; output instruction is illegal
occupancy_o  out  $clog2(DEPTH+1)  current buffer count

Behaviour:
- Reset: valid_o=0, decode_state_o='0, reg_meta_o='0, illegal_o=0, count=0, rd/wr pointers=0.
- push = valid_i & ready_o & ~squash_i. load = (~valid_o | ready_i) & ~squash_i.
- Head source:
  - count>0: buffer entry at rd_ptr.
  - count==0, BYPASS=1: inst_i/fetch_state_i.
  - count==0, BYPASS=0: no head.
- Head is decoded combinationally; RF ports are driven from the head instruction.
- pop = load & head present.
- On pop, the output register captures the decoder/immed_gen outputs, pc, next_pc, rf_rs1_i/rf_rs2_i, reg_meta fields, and illegal.
- valid_o <= 1 on pop. valid_o <= 0 when load and no head.
- Bypass case (count==0, push & load): the entry goes straight into the output register; the buffer is not written and count is unchanged.
- Normal push writes mem[wr_ptr] and increments wr_ptr, wrapping modulo DEPTH. Pop from the buffer increments rd_ptr, also wrapping.
- count update:
  - +1 on push only
  - -1 on pop only
  - unchanged on simultaneous push and buffer pop
- Latency to valid_o:
  - 1 cycle via bypass
  - 2 cycles via buffer (write, then pop)
  - queued entries are delayed further
- Full: ready_o=0. No push even if a pop occurs in the same cycle; ready_o rises the cycle after the pop.
- Empty with no bypass: no pop; valid_o drops after the current output is accepted.
- Backpressure: while valid_o & ~ready_i, all output fields hold stable.
- rf_wr_en output = decoder rf_wr_en & (rd != 0).
- Illegal: set when inst[1:0] != 2'b11, or when inst[6:0] is not one of 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011. An illegal instruction forces rf_wr_en, mem_read, mem_write and rd_used to 0; illegal_o=1.
- squash_i (highest priority, synchronous):
  - count<=0, pointers<=0, valid_o<=0
  - same-cycle push is dropped
  - output data fields may keep old values
  - ready_o returns to 1 the next cycle
- Reset asserted mid-operation: immediate return to reset values; buffer contents are don't-care.
- RF data is sampled at pop time. Hazards against in-flight writes are resolved downstream via reg_meta_o.

Decomposition:
- Shared package (defs.svh):
  - fetch_entry_t {inst[31:0], fetch_state_t}
  - RV32I opcode localparams (OPC_LUI … OPC_SYSTEM)
  - existing decode_state_t / reg_meta_t unchanged
- Sub-module decode_fifo #(DEPTH, type T=fetch_entry_t): storage, pointers, count, full/empty, head out, flush. Decode, bypass mux and output register stay in the top.

Test Plan:
- Bypass path: BYPASS=1, empty, ready_i=1, push ADDI x5,x0,7 (0x00700293) at pc 0x100 → next cycle valid_o=1, pc=0x100, i_immed=7, rf_wr_en=1, occupancy_o=0.
- Fill to full: DEPTH=2, ready_i=0, push 3 instrs → 1st in output register, 2 in buffer. Then ready_o=0, occupancy_o=2, and the 4th valid_i is ignored. Release ready_i → the three emerge in order, ready_o=1 the cycle after the first buffer pop.
- Simultaneous push and pop at count=1 for 10 cycles → occupancy_o constant 1, in-order output, pointer wrap covered.
- Squash with count=2 and valid_o=1, push same cycle → next cycle valid_o=0, occupancy_o=0, ready_o=1; pushed instr never appears.
- Illegal/rd=x0: inst 0x00000000 → illegal_o=1, rf_wr_en=0, mem_write=0. ADDI x0,x0,1 → illegal_o=0, rf_wr_en=0.
- Reset mid-stream: with valid_o=1 and occupancy_o=2, assert rst_ni between edges → outputs zero asynchronously; after release the first push behaves as in the bypass-path scenario.
